// File: rtl/reg_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// PkgRegWbArbiter
//
// Shared types and sizing for the register-file writeback arbiter.
//   NUM_REGS  number of architectural registers (a power of two, so every
//             select value names a real register)
//   SEL_W     register select width
//   DATA_W    register data width
//   RegSel_t / RegData_t / WbReq_t   select, data and {sel, data} request
//   rrNext()  round-robin successor of a requester index
// ---------------------------------------------------------------------------
package PkgRegWbArbiter;

    localparam int NUM_REGS = 16;
    localparam int SEL_W    = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    typedef logic [SEL_W-1:0]  RegSel_t;
    typedef logic [DATA_W-1:0] RegData_t;

    typedef struct packed {
        RegSel_t  sel;
        RegData_t data;
    } WbReq_t;

    // Successor of idx in a ring of n requesters.
    function automatic int rrNext(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//
// Combinational round-robin priority select. Scans from ptr_i upward,
// wrapping modulo NUM_REQ, and picks the first asserted valid bit.
//   valid_i  requesters eligible for a grant this cycle
//   ptr_i    requester with highest priority
//   grant_o  one-hot grant (all zero when nothing is valid)
//   idx_o    index of the granted requester (0 when nothing is valid)
//   any_o    a grant was made
// ---------------------------------------------------------------------------
module rr_picker
    import PkgRegWbArbiter::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    // Walk the ring once starting at the pointer; the first hit wins and
    // later candidates are ignored through the found flag.
    always_comb begin
        int               k;
        logic [PTR_W-1:0] kIdx;
        logic             found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        kIdx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr_i) + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kIdx = PTR_W'(k);
            if (!found && valid_i[kIdx]) begin
                grant_o[kIdx] = 1'b1;
                idx_o         = kIdx;
                found         = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//
// Shares the register file's single write port among NUM_REQ writeback
// requesters with round-robin fairness and a one-cycle registered issue
// stage, and keeps a per-register pending scoreboard for decode stalls.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/sel/data       per-requester write requests
//   req_ready                request accepted this cycle (combinational)
//   wb_hold                  blocks new grants; the issue stage still drains
//   claim_valid, claim_sel   decode marks a register as having a producer
//   wr_en, wr_sel, wr_data   register file write port (registered)
//   pending                  scoreboard bitmap, bit 0 always clear
//
// Configuration macro
//   REG_WB_ARB_DROP_R0_EN    requests targeting r0 are accepted at once,
//                            bypassing arbitration and wb_hold, and never
//                            reach the write port. When undefined, r0
//                            requests arbitrate and issue like any other.
// ---------------------------------------------------------------------------
module reg_wb_arbiter
    import PkgRegWbArbiter::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wb_hold,
    input  logic                           claim_valid,
    input  logic [SEL_W-1:0]               claim_sel,
    output logic                           wr_en,
    output logic [SEL_W-1:0]               wr_sel,
    output logic [DATA_W-1:0]              wr_data,
    output logic [NUM_REGS-1:0]            pending
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]    rrPtr_q, rrPtr_d;
    logic                wrEn_q, wrEn_d;
    WbReq_t              issue_q, issue_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic [NUM_REQ-1:0]  arbValid;
    logic [NUM_REQ-1:0]  dropReady;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grantIdx;
    logic                grantAny;

    // Decide which requests compete for the write port and which (r0 drops)
    // are simply absorbed without touching the pointer or the issue stage.
    always_comb begin
        arbValid  = '0;
        dropReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef REG_WB_ARB_DROP_R0_EN
            dropReady[i] = req_valid[i] && (req_sel[i] == '0);
            arbValid[i]  = req_valid[i] && !wb_hold && (req_sel[i] != '0);
`else
            arbValid[i]  = req_valid[i] && !wb_hold;
`endif
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid_i (arbValid),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    // Gated by rst_n so nothing is accepted while the block is held in reset.
    assign req_ready = (grant | dropReady) & {NUM_REQ{rst_n}};

    // Next state for pointer, issue stage and scoreboard. A claim is applied
    // after the write clear so a same-cycle claim of the written register
    // (a newer producer) wins.
    always_comb begin
        rrPtr_d   = rrPtr_q;
        wrEn_d    = grantAny;
        issue_d   = issue_q;
        pending_d = pending_q;

        if (grantAny) begin
            rrPtr_d      = PTR_W'(rrNext(int'(grantIdx), NUM_REQ));
            issue_d.sel  = req_sel[grantIdx];
            issue_d.data = req_data[grantIdx];
        end

        if (wrEn_q) begin
            pending_d[issue_q.sel] = 1'b0;
        end
        if (claim_valid) begin
            pending_d[claim_sel] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q   <= '0;
            wrEn_q    <= 1'b0;
            issue_q   <= '0;
            pending_q <= '0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            wrEn_q    <= wrEn_d;
            issue_q   <= issue_d;
            pending_q <= pending_d;
        end
    end

    assign wr_en   = wrEn_q;
    assign wr_sel  = issue_q.sel;
    assign wr_data = issue_q.data;
    assign pending = pending_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Directed and randomized stimulus for reg_wb_arbiter, checked every cycle
// against a behavioural model: a ring-scan arbiter over an integer pointer,
// a pending bitmap and a single staged write.
// ---------------------------------------------------------------------------
module tb_reg_wb_arbiter;

    localparam int N    = 3;
    localparam int NREG = 16;
    localparam int SW   = 4;
    localparam int DW   = 32;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    logic [N-1:0][SW-1:0]   req_sel;
    logic [N-1:0][DW-1:0]   req_data;
    logic [N-1:0]           req_ready;
    logic                   wb_hold;
    logic                   claim_valid;
    logic [SW-1:0]          claim_sel;
    logic                   wr_en;
    logic [SW-1:0]          wr_sel;
    logic [DW-1:0]          wr_data;
    logic [NREG-1:0]        pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              mPtr;
    logic            mWrEn;
    logic [SW-1:0]   mWrSel;
    logic [DW-1:0]   mWrData;
    logic [NREG-1:0] mPend;

    reg_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_hold     (wb_hold),
        .claim_valid (claim_valid),
        .claim_sel   (claim_sel),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .pending     (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Which requests should be accepted right now, and who wins arbitration.
    task automatic modelReady(output logic [N-1:0] rdy, output int gnt);
        logic elig;
        int   k;
        rdy = '0;
        gnt = -1;
        if (rst_n !== 1'b1) return;
`ifdef REG_WB_ARB_DROP_R0_EN
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_sel[i] == 0) rdy[i] = 1'b1;
        end
`endif
        if (!wb_hold) begin
            for (int off = 0; off < N; off++) begin
                k    = (mPtr + off) % N;
                elig = req_valid[k];
`ifdef REG_WB_ARB_DROP_R0_EN
                if (req_sel[k] == 0) elig = 1'b0;
`endif
                if (gnt < 0 && elig) gnt = k;
            end
        end
        if (gnt >= 0) rdy[gnt] = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs as driven.
    task automatic modelEdge();
        logic [N-1:0] rdy;
        int           g;
        modelReady(rdy, g);
        if (mWrEn) mPend[mWrSel] = 1'b0;
        if (claim_valid && claim_sel != 0) mPend[claim_sel] = 1'b1;
        mWrEn = (g >= 0);
        if (g >= 0) begin
            mWrSel  = req_sel[g];
            mWrData = req_data[g];
            mPtr    = (g + 1) % N;
        end
    endtask

    task automatic modelReset();
        mPtr    = 0;
        mWrEn   = 1'b0;
        mWrSel  = '0;
        mWrData = '0;
        mPend   = '0;
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] rdy;
        int           g;
        modelReady(rdy, g);
        checkOne({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
        checkOne({tag, ".wr_en"},     64'(wr_en),     64'(mWrEn));
        checkOne({tag, ".wr_sel"},    64'(wr_sel),    64'(mWrSel));
        checkOne({tag, ".wr_data"},   64'(wr_data),   64'(mWrData));
        checkOne({tag, ".pending"},   64'(pending),   64'(mPend));
    endtask

    task automatic applyStimulus(input logic [N-1:0] v,
                                 input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                                 input logic [SW-1:0] s2,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2,
                                 input logic h, input logic cv, input logic [SW-1:0] cs);
        req_valid   = v;
        req_sel[0]  = s0;
        req_sel[1]  = s1;
        req_sel[2]  = s2;
        req_data[0] = d0;
        req_data[1] = d1;
        req_data[2] = d2;
        wb_hold     = h;
        claim_valid = cv;
        claim_sel   = cs;
    endtask

    task automatic idle();
        applyStimulus('0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic runCycle(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] order [6];
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst_n = 1'b0;
        idle();
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fairness");
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, 0);
            #1;
            checkOne("fair.order", 64'(req_ready), 64'(order[c]));
            runCycle("fair");
        end
        idle();
        #1;
        checkOne("fair.tail_wr_en", 64'(wr_en), 64'd1);
        runCycle("fair_tail");

        $display("[TB] single request");
        applyStimulus(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 0);
        #1;
        checkOne("single.ready", 64'(req_ready), 64'h1);
        runCycle("single0");
        idle();
        #1;
        checkOne("single.wr_en",   64'(wr_en),   64'd1);
        checkOne("single.wr_sel",  64'(wr_sel),  64'd5);
        checkOne("single.wr_data", 64'(wr_data), 64'hDEADBEEF);
        runCycle("single1");
        idle();
        #1;
        checkOne("single.wr_en_drop", 64'(wr_en), 64'd0);
        runCycle("single2");

        $display("[TB] hold");
        applyStimulus(3'b001, 6, 0, 0, 32'hA0, 0, 0, 1'b0, 1'b0, 0);
        runCycle("hold_pre");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b010, 0, 8, 0, 0, 32'hB1, 0, 1'b1, 1'b0, 0);
            #1;
            checkOne("hold.ready", 64'(req_ready), 64'd0);
            runCycle("hold");
        end
        applyStimulus(3'b010, 0, 8, 0, 0, 32'hB1, 0, 1'b0, 1'b0, 0);
        #1;
        checkOne("hold.release", 64'(req_ready), 64'h2);
        runCycle("hold_rel");

        $display("[TB] scoreboard");
        applyStimulus('0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 7);
        runCycle("sb_claim");
        applyStimulus(3'b100, 0, 0, 7, 0, 0, 32'hC7, 1'b0, 1'b0, 0);
        #1;
        checkOne("sb.set", 64'(pending[7]), 64'd1);
        runCycle("sb_req");
        applyStimulus('0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 7);
        runCycle("sb_collide");
        applyStimulus(3'b100, 0, 0, 7, 0, 0, 32'hC8, 1'b0, 1'b0, 0);
        #1;
        checkOne("sb.kept", 64'(pending[7]), 64'd1);
        runCycle("sb_req2");
        idle();
        runCycle("sb_wr2");
        idle();
        #1;
        checkOne("sb.cleared", 64'(pending[7]), 64'd0);
        runCycle("sb_done");

        $display("[TB] r0 handling");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(3'b011, 0, 3, 0, 32'hE0, 32'hE3, 0, 1'b0, 1'b0, 0);
            runCycle("r0");
        end
        applyStimulus('0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0);
        runCycle("r0_claim");
        idle();
        #1;
        checkOne("r0.pending0", 64'(pending[0]), 64'd0);
        runCycle("r0_after");

        $display("[TB] reset mid-flight");
        applyStimulus(3'b010, 0, 9, 0, 0, 32'hF9, 0, 1'b0, 1'b1, 4);
        runCycle("rst_pre");
        applyStimulus(3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 0);
        #1;
        checkOne("rst.pre_wr_en", 64'(wr_en), 64'd1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOne("rst.wr_en",   64'(wr_en),     64'd0);
        checkOne("rst.wr_sel",  64'(wr_sel),    64'd0);
        checkOne("rst.wr_data", 64'(wr_data),   64'd0);
        checkOne("rst.pending", 64'(pending),   64'd0);
        checkOne("rst.ready",   64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOne("rst.first_grant", 64'(req_ready), 64'h1);
        runCycle("rst_post");

        $display("[TB] random");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(N'($urandom_range(0, 7)),
                          SW'($urandom_range(0, 15)), SW'($urandom_range(0, 15)),
                          SW'($urandom_range(0, 15)),
                          $urandom, $urandom, $urandom,
                          ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)),
                          SW'($urandom_range(0, 15)));
            runCycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
